seg_scan_display: RTL and testbench

Parametrised multi-channel seven-segment scan display. It is the successor of the fixed two-value, eight-digit output unit that sits after the processor's outval/outsel/outdisplay interface.
- Latches processor writes into a bank of NUM_CH value registers.
- Time-multiplexes their hex digits onto one shared segment bus.
- Adds per-channel leading-zero blanking, a blink mode and a halt indicator.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_scan_display_hex7seg.sv | 17 +
 rtl/seg_scan_display.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared constants for the seven-segment scan display:
//     - segment bit positions inside the 8-bit bus {dp,g,f,e,d,c,b,a}
//     - SEG_BLANK, the all-segments-off pattern
//     - HEX_SEG_TABLE, hex digit 0..F to segments g..a (active-high);
//       'b' and 'd' use the lowercase glyphs so they differ from '8' and '0'.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Index = nibble value, entry = {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
//   Purely combinational hex-to-seven-segment encoder.
//   Ports:
//     hex_i  [3:0]  nibble to display
//     seg_o  [6:0]  segments {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//   Multi-channel seven-segment scan display. Processor writes land in a bank
//   of NUM_CH value registers; their hex digits are time-multiplexed onto one
//   shared segment bus, one digit slot every SCAN_DIV cycles. Supports
//   per-channel leading-zero blanking, whole-display blink and a halt dot.
//
//   Ports:
//     clock     system clock, rising edge
//     n_reset   asynchronous active-low reset
//     wr_en     write strobe (one cycle per write)
//     wr_sel    target channel index
//     wr_val    value to store
//     lz_blank  level, blank leading zeros inside each channel
//     blink_en  level, flash the whole display
//     halt      level, lights dp on digit 0
//     wr_ack    one-cycle pulse for each accepted write
//     seg       {dp,g,f,e,d,c,b,a}, active-high, registered
//     dig_sel   one-hot active-low digit enable, registered
//
//   Write handshake: there is no back-pressure. Every cycle with wr_en=1 and
//   wr_sel < NUM_CH stores wr_val on that edge and raises wr_ack for exactly
//   the following cycle; a write to a non-existent channel is dropped with no
//   wr_ack. Writes may be issued on consecutive cycles.
// -----------------------------------------------------------------------------
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int VAL_W     = 16,
    parameter int SEL_W     = 4,
    parameter int SCAN_DIV  = 4000,
    parameter int BLINK_DIV = 2000000
) (
    input  logic                        clock,
    input  logic                        n_reset,
    input  logic                        wr_en,
    input  logic [SEL_W-1:0]            wr_sel,
    input  logic [VAL_W-1:0]            wr_val,
    input  logic                        lz_blank,
    input  logic                        blink_en,
    input  logic                        halt,
    output logic                        wr_ack,
    output logic [7:0]                  seg,
    output logic [NUM_CH*VAL_W/4-1:0]   dig_sel
);

    localparam int NUM_DIG = NUM_CH * VAL_W / 4;
    localparam int DPC     = VAL_W / 4;
    localparam int DIG_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [VAL_W-1:0]   ch_q      [NUM_CH];
    logic [VAL_W-1:0]   ch_d      [NUM_CH];
    logic               wr_ack_q, wr_ack_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [DIG_W-1:0]   dig_idx_q, dig_idx_d;
    logic [7:0]         seg_q, seg_d;
    logic [NUM_DIG-1:0] dig_sel_q, dig_sel_d;

    logic               scan_tick;
    logic               blink_tc;
    logic [NUM_CH*VAL_W-1:0] flat_vals;
    logic [VAL_W-1:0]   chan_word;
    logic [3:0]         nibble;
    logic               lz_hit;
    logic [6:0]         hex_seg;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    always_comb begin
        ch_d     = ch_q;
        wr_ack_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (32'(wr_sel) == c)) begin
                ch_d[c]  = wr_val;
                wr_ack_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan and blink timebases
    // ------------------------------------------------------------------
    assign scan_tick = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign blink_tc  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    always_comb begin
        scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_tc ? ~blink_on_q : blink_on_q;
        dig_idx_d   = dig_idx_q;
        if (scan_tick) begin
            dig_idx_d = (dig_idx_q == DIG_W'(NUM_DIG - 1)) ? '0 : dig_idx_q + DIG_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit mux: looks at the index being entered (dig_idx_d) and at the
    // pre-write register contents, so a write on a tick edge shows up on the
    // next visit to that digit.
    // ------------------------------------------------------------------
    always_comb begin
        flat_vals = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            flat_vals[c*VAL_W +: VAL_W] = ch_q[c];
        end
    end

    always_comb begin
        chan_word = '0;
        nibble    = '0;
        lz_hit    = 1'b0;
        for (int d = 0; d < NUM_DIG; d++) begin
            if (dig_idx_d == DIG_W'(d)) begin
                chan_word = flat_vals[(d / DPC) * VAL_W +: VAL_W];
                nibble    = chan_word[(d % DPC) * 4 +: 4];
                // Blank only if this nibble and everything above it in the
                // channel is zero; the channel's lowest digit always shows.
                lz_hit    = ((d % DPC) != 0) && ((chan_word >> ((d % DPC) * 4)) == '0);
            end
        end
    end

    hex7seg u_hex7seg (
        .hex_i (nibble),
        .seg_o (hex_seg)
    );

    // ------------------------------------------------------------------
    // Output registers: seg and dig_sel only move together on a scan tick.
    // The blink phase used is the one before this edge's toggle.
    // ------------------------------------------------------------------
    always_comb begin
        seg_d     = seg_q;
        dig_sel_d = dig_sel_q;
        if (scan_tick) begin
            seg_d                = SEG_BLANK;
            seg_d[SEG_G:SEG_A]   = (lz_blank && lz_hit) ? 7'h00 : hex_seg;
            seg_d[SEG_DP]        = halt && (dig_idx_d == '0);
            dig_sel_d            = (blink_en && !blink_on_q) ? '1
                                 : ~(NUM_DIG'(1) << dig_idx_d);
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_q[c] <= '0;
            end
            wr_ack_q    <= 1'b0;
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            dig_idx_q   <= '0;
            seg_q       <= SEG_BLANK;
            dig_sel_q   <= '1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_q[c] <= ch_d[c];
            end
            wr_ack_q    <= wr_ack_d;
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            dig_idx_q   <= dig_idx_d;
            seg_q       <= seg_d;
            dig_sel_q   <= dig_sel_d;
        end
    end

    assign wr_ack  = wr_ack_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//   Self-checking bench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=64.
//   A cycle-count based reference model predicts seg/dig_sel/wr_ack every
//   cycle; directed sections pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

    localparam int NUM_CH    = 2;
    localparam int VAL_W     = 16;
    localparam int SEL_W     = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 64;
    localparam int NUM_DIG   = NUM_CH * VAL_W / 4;
    localparam int DPC       = VAL_W / 4;

    // ---------------- clock / reset ----------------
    logic               clock    = 1'b0;
    logic               n_reset  = 1'b0;
    logic               wr_en    = 1'b0;
    logic [SEL_W-1:0]   wr_sel   = '0;
    logic [VAL_W-1:0]   wr_val   = '0;
    logic               lz_blank = 1'b0;
    logic               blink_en = 1'b0;
    logic               halt     = 1'b0;
    logic               wr_ack;
    logic [7:0]         seg;
    logic [NUM_DIG-1:0] dig_sel;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seg_scan_display #(
        .NUM_CH    (NUM_CH),
        .VAL_W     (VAL_W),
        .SEL_W     (SEL_W),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_val   (wr_val),
        .lz_blank (lz_blank),
        .blink_en (blink_en),
        .halt     (halt),
        .wr_ack   (wr_ack),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    // ---------------- scoreboard helpers ----------------
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Edge m_n after reset release: a digit slot starts on every edge with
    // m_n % SCAN_DIV == 0 and shows digit (m_n/SCAN_DIV) % NUM_DIG. The blink
    // phase seen by that edge has flipped once per BLINK_DIV earlier edges.
    logic [6:0]         ref_hex [16];
    logic [VAL_W-1:0]   m_ch [NUM_CH];
    int                 m_n;
    int                 m_d, m_c, m_p;
    logic               m_on, m_blank, m_acc;
    logic [3:0]         m_nib;
    logic [7:0]         exp_seg = 8'h00;
    logic [NUM_DIG-1:0] exp_dig = '1;
    logic               exp_ack = 1'b0;

    initial begin
        ref_hex = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int c = 0; c < NUM_CH; c++) m_ch[c] = '0;
        m_n = 0;
        forever begin
            @(posedge clock or negedge n_reset);
            if (!n_reset) begin
                for (int c = 0; c < NUM_CH; c++) m_ch[c] = '0;
                m_n     = 0;
                exp_seg = 8'h00;
                exp_dig = '1;
                exp_ack = 1'b0;
            end else begin
                m_n++;
                m_acc   = wr_en && (int'(wr_sel) < NUM_CH);
                exp_ack = m_acc;
                if (m_n % SCAN_DIV == 0) begin
                    m_d     = (m_n / SCAN_DIV) % NUM_DIG;
                    m_c     = m_d / DPC;
                    m_p     = m_d % DPC;
                    m_on    = (((m_n - 1) / BLINK_DIV) % 2) == 0;
                    m_nib   = 4'((m_ch[m_c] >> (4 * m_p)) & 16'hF);
                    m_blank = lz_blank && (m_p != 0) && ((m_ch[m_c] >> (4 * m_p)) == 0);
                    exp_seg = {halt && (m_d == 0), m_blank ? 7'h00 : ref_hex[m_nib]};
                    exp_dig = (blink_en && !m_on) ? '1 : ~(NUM_DIG'(1) << m_d);
                end
                if (m_acc) m_ch[int'(wr_sel)] = wr_val;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_dig_sel", 32'(dig_sel), 32'(exp_dig));
            chk("model_wr_ack", 32'(wr_ack), 32'(exp_ack));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_digit(input int d, output logic [7:0] s);
        logic [NUM_DIG-1:0] want;
        int budget;
        want   = ~(NUM_DIG'(1) << d);
        budget = 0;
        while (dig_sel == want && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        while (dig_sel != want && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_digit%0d: got timeout expected digit select", d);
        end
        s = seg;
    endtask

    task automatic check_scan(input string tag);
        logic [7:0] s;
        logic [7:0] e;
        for (int d = 0; d < NUM_DIG; d++) begin
            wait_digit(d, s);
            e = exp_q.pop_front();
            chk($sformatf("%s_d%0d", tag, d), 32'(s), 32'(e));
        end
    endtask

    task automatic do_write(input logic [SEL_W-1:0] sel, input logic [VAL_W-1:0] val,
                            input logic ack_exp);
        @(negedge clock);
        wr_en  = 1'b1;
        wr_sel = sel;
        wr_val = val;
        @(negedge clock);
        wr_en = 1'b0;
        chk("wr_ack_pulse", 32'(wr_ack), 32'(ack_exp));
        @(negedge clock);
        chk("wr_ack_clear", 32'(wr_ack), 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] s;
        int         cnt;

        repeat (3) @(negedge clock);
        n_reset = 1'b1;

        // Random activity so the later reset lands mid-scan with live state.
        repeat (50) begin
            @(negedge clock);
            wr_en  = 1'($urandom_range(0, 1));
            wr_sel = SEL_W'($urandom_range(0, 3));
            wr_val = VAL_W'($urandom);
        end
        @(negedge clock);
        wr_en = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clock);
        #3 n_reset = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg), 32'h00);
        chk("async_rst_dig_sel", 32'(dig_sel), 32'hFF);
        chk("async_rst_wr_ack", 32'(wr_ack), 32'h0);
        @(negedge clock);
        @(negedge clock);
        n_reset = 1'b1;

        // First tick after release is on edge 4 and selects digit 1.
        repeat (3) @(negedge clock);
        chk("pre_tick_dig_sel", 32'(dig_sel), 32'hFF);
        @(negedge clock);
        chk("first_tick_dig_sel", 32'(dig_sel), 32'hFD);
        chk("first_tick_seg", 32'(seg), 32'h3F);

        // Writes: one single, then a back-to-back pair.
        do_write(SEL_W'(0), 16'h1234, 1'b1);
        @(negedge clock);
        wr_en = 1'b1; wr_sel = SEL_W'(1); wr_val = 16'h0000;
        @(negedge clock);
        wr_val = 16'hABCD;
        chk("b2b_ack_first", 32'(wr_ack), 32'h1);
        @(negedge clock);
        wr_en = 1'b0;
        chk("b2b_ack_second", 32'(wr_ack), 32'h1);
        @(negedge clock);
        chk("b2b_ack_clear", 32'(wr_ack), 32'h0);

        exp_q = '{8'h66, 8'h4F, 8'h5B, 8'h06, 8'h5E, 8'h39, 8'h7C, 8'h77};
        check_scan("hex");

        // Out-of-range channel: ignored.
        do_write(SEL_W'(5), 16'hFFFF, 1'b0);
        exp_q = '{8'h66, 8'h4F, 8'h5B, 8'h06, 8'h5E, 8'h39, 8'h7C, 8'h77};
        check_scan("ignored");

        // Leading-zero blanking.
        lz_blank = 1'b1;
        do_write(SEL_W'(0), 16'h0040, 1'b1);
        do_write(SEL_W'(1), 16'h0000, 1'b1);
        exp_q = '{8'h3F, 8'h66, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h00};
        check_scan("lz");

        // Halt dot only on digit 0.
        halt = 1'b1;
        wait_digit(0, s);
        chk("halt_d0", 32'(s), 32'hBF);
        wait_digit(1, s);
        chk("halt_d1", 32'(s), 32'h66);
        halt = 1'b0;

        // Write landing on the very edge that selects digit 0.
        lz_blank = 1'b0;
        do_write(SEL_W'(0), 16'h1234, 1'b1);
        wait_digit(7, s);
        repeat (3) @(negedge clock);
        wr_en = 1'b1; wr_sel = SEL_W'(0); wr_val = 16'h5678;
        @(negedge clock);
        wr_en = 1'b0;
        chk("same_edge_dig_sel", 32'(dig_sel), 32'hFE);
        chk("same_edge_old", 32'(seg), 32'h66);
        wait_digit(0, s);
        chk("same_edge_new", 32'(s), 32'h7F);

        // Blink: half of every 128-cycle window is dark.
        blink_en = 1'b1;
        repeat (16) @(negedge clock);
        cnt = 0;
        repeat (256) begin
            @(negedge clock);
            if (dig_sel == '1) cnt++;
        end
        chk("blink_dark_cycles", 32'(cnt), 32'd128);
        blink_en = 1'b0;

        // Randomized traffic against the model.
        repeat (1500) begin
            @(negedge clock);
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_sel = SEL_W'($urandom_range(0, 5));
            wr_val = VAL_W'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 99) == 0) halt     = ~halt;
            if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
        end
        @(negedge clock);
        wr_en = 1'b0;
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
